// File: rtl/ic_test_sequencer_if.sv
// Signal bundle between the IC test sequencer and its surroundings (control, vector ROM, DUT pins).
// err_count exists only when IC_TEST_FULL_SCAN_EN is defined.
interface ic_test_sequencer_if #(
    parameter int PINS   = 14,
    parameter int ADDR_W = 8
);
    logic [31:0]       number;
    logic              icg;
    logic [ADDR_W-1:0] vec_addr;
    logic [3*PINS:0]   vec_data;
    logic [PINS-1:0]   pin_drive;
    logic [PINS-1:0]   pin_oe;
    logic [PINS-1:0]   pin_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic              unknown_ic;
    logic [ADDR_W-1:0] fail_idx;
`ifdef IC_TEST_FULL_SCAN_EN
    logic [ADDR_W-1:0] err_count;
`endif

    modport slave (
        input  number, icg, vec_data, pin_in,
`ifdef IC_TEST_FULL_SCAN_EN
        output err_count,
`endif
        output vec_addr, pin_drive, pin_oe, busy, done, pass, unknown_ic, fail_idx
    );

    modport master (
        output number, icg, vec_data, pin_in,
`ifdef IC_TEST_FULL_SCAN_EN
        input  err_count,
`endif
        input  vec_addr, pin_drive, pin_oe, busy, done, pass, unknown_ic, fail_idx
    );
endinterface

// File: rtl/ic_test_sequencer.sv
// Functional tester for 14-pin logic ICs: maps an IC number to a vector-ROM base and runs the vectors.
// Define IC_TEST_FULL_SCAN_EN to run every vector and count failures instead of stopping at the first.
module ic_test_sequencer #(
    parameter int PINS          = 14,
    parameter int ADDR_W        = 8,
    parameter int SETTLE_CYCLES = 50
) (
    input  logic               iCLK,
    input  logic               iRST,
    ic_test_sequencer_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // DIP supply pins: GND at the middle, VCC at the top; never driven, never compared
    localparam logic [PINS-1:0] PWR_MASK = (PINS'(1) << (PINS/2 - 1)) | (PINS'(1) << (PINS - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_FETCH, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              icg_q;
    logic [PINS-1:0]   sync1_q, sync2_q;
    logic [31:0]       number_q, number_d;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PINS-1:0]   expect_q, expect_d;
    logic [PINS-1:0]   mask_q, mask_d;
    logic              last_q, last_d;
    logic [PINS-1:0]   pin_drive_q, pin_drive_d;
    logic [PINS-1:0]   pin_oe_q, pin_oe_d;
    logic              pass_q, pass_d;
    logic              unknown_q, unknown_d;
    logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
`ifdef IC_TEST_FULL_SCAN_EN
    logic [ADDR_W-1:0] err_q, err_d;
`endif

    logic              start, hit, mismatch, wrap, bad;
    logic [ADDR_W-1:0] base;
    logic [PINS-1:0]   v_drive, v_expect, v_mask;

    assign start    = bus.icg & ~icg_q & (state_q == S_IDLE);
    assign v_drive  = bus.vec_data[PINS-1:0];
    assign v_expect = bus.vec_data[2*PINS-1:PINS];
    assign v_mask   = bus.vec_data[3*PINS-1:2*PINS] & ~PWR_MASK;
    assign mismatch = |((sync2_q ^ expect_q) & mask_q);
    assign wrap     = ~last_q & (vec_addr_q == '1);
    assign bad      = mismatch | wrap;

    always_comb begin
        hit  = 1'b1;
        base = '0;
        case (number_q)
            32'd7400: base = ADDR_W'('h00);
            32'd7402: base = ADDR_W'('h10);
            32'd7404: base = ADDR_W'('h20);
            32'd7408: base = ADDR_W'('h30);
            32'd7432: base = ADDR_W'('h40);
            32'd7486: base = ADDR_W'('h50);
            default:  hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        number_d    = number_q;
        vec_addr_d  = vec_addr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        expect_d    = expect_q;
        mask_d      = mask_q;
        last_d      = last_q;
        pin_drive_d = pin_drive_q;
        pin_oe_d    = pin_oe_q;
        pass_d      = pass_q;
        unknown_d   = unknown_q;
        fail_idx_d  = fail_idx_q;
`ifdef IC_TEST_FULL_SCAN_EN
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                pin_oe_d    = '0;
                pin_drive_d = '0;
                if (start) begin
                    number_d   = bus.number;
                    pass_d     = 1'b0;
                    unknown_d  = 1'b0;
                    fail_idx_d = '0;
`ifdef IC_TEST_FULL_SCAN_EN
                    err_d      = '0;
`endif
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!hit) begin
                    unknown_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    vec_addr_d = base;
                    idx_d      = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_APPLY;
            S_APPLY: begin
                expect_d    = v_expect;
                mask_d      = v_mask;
                last_d      = bus.vec_data[3*PINS];
                pin_drive_d = v_drive & ~v_mask & ~PWR_MASK;
                pin_oe_d    = ~v_mask & ~PWR_MASK;
                cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
`ifdef IC_TEST_FULL_SCAN_EN
                // Keep running after a failure; only the first one sets fail_idx
                if (bad) begin
                    err_d = err_q + ADDR_W'(1);
                    if (err_q == '0) fail_idx_d = idx_q;
                end
                if (last_q || wrap) begin
                    pass_d  = ~bad & (err_q == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + ADDR_W'(1);
                    vec_addr_d = vec_addr_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
`else
                if (bad) begin
                    fail_idx_d = idx_q;
                    pass_d     = 1'b0;
                    state_d    = S_DONE;
                end else if (last_q) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + ADDR_W'(1);
                    vec_addr_d = vec_addr_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
`endif
                if (state_d == S_DONE) begin
                    pin_oe_d    = '0;
                    pin_drive_d = '0;
                end
            end
            S_DONE: begin
                pin_oe_d    = '0;
                pin_drive_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            icg_q       <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            number_q    <= '0;
            vec_addr_q  <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            expect_q    <= '0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            pin_drive_q <= '0;
            pin_oe_q    <= '0;
            pass_q      <= 1'b0;
            unknown_q   <= 1'b0;
            fail_idx_q  <= '0;
`ifdef IC_TEST_FULL_SCAN_EN
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            icg_q       <= bus.icg;
            sync1_q     <= bus.pin_in;
            sync2_q     <= sync1_q;
            number_q    <= number_d;
            vec_addr_q  <= vec_addr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            expect_q    <= expect_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            pin_drive_q <= pin_drive_d;
            pin_oe_q    <= pin_oe_d;
            pass_q      <= pass_d;
            unknown_q   <= unknown_d;
            fail_idx_q  <= fail_idx_d;
`ifdef IC_TEST_FULL_SCAN_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.vec_addr   = vec_addr_q;
    assign bus.pin_drive  = pin_drive_q;
    assign bus.pin_oe     = pin_oe_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = pass_q;
    assign bus.unknown_ic = unknown_q;
    assign bus.fail_idx   = fail_idx_q;
`ifdef IC_TEST_FULL_SCAN_EN
    assign bus.err_count  = err_q;
`endif
endmodule
